// File: rtl/pipe_ctrl_pkg.sv
// Shared types for backend stall/flush control.
// Index fields are fixed-width so the winner record is parameter-independent.
package pipe_ctrl_pkg;

  localparam int IDX_W = 8;

  typedef logic [IDX_W-1:0] stage_idx_t;
  typedef logic [IDX_W-1:0] lane_idx_t;
  typedef logic [IDX_W-1:0] order_idx_t;

  typedef struct packed {
    logic       valid;
    stage_idx_t stage;
    order_idx_t order;
    lane_idx_t  lane;
    logic       excl_self;
  } win_t;

  function automatic int order_w(input int num_pipe);
    return (num_pipe > 1) ? $clog2(num_pipe) : 1;
  endfunction

endpackage

// File: rtl/clr_oldest_arb.sv
// Picks the oldest qualified flush request across all lanes and stages.
// Oldest = highest stage, then lowest in-bundle order.
module clr_oldest_arb
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_PIPE  = 2,
  parameter int NUM_STAGE = 3,
  parameter int ORDER_W   = order_w(NUM_PIPE)
) (
  input  logic [NUM_PIPE-1:0][NUM_STAGE-1:0]              slot_valid,
  input  logic [NUM_PIPE-1:0][NUM_STAGE-1:0]              clr_req,
  input  logic [NUM_PIPE-1:0][NUM_STAGE-1:0]              excl_self,
  input  logic [NUM_PIPE-1:0][NUM_STAGE-1:0][ORDER_W-1:0] slot_order,
  output win_t                                            win
);

  always_comb begin
    order_idx_t ord;
    stage_idx_t st;
    ord = '0;
    st  = '0;
    win = '0;
    for (int s = 0; s < NUM_STAGE; s++) begin
      for (int l = 0; l < NUM_PIPE; l++) begin
        ord = (NUM_PIPE > 1) ? order_idx_t'(slot_order[l][s]) : '0;
        st  = stage_idx_t'(s);
        if (slot_valid[l][s] && clr_req[l][s]) begin
          if (!win.valid || st > win.stage ||
              (st == win.stage && ord < win.order)) begin
            win.valid     = 1'b1;
            win.stage     = st;
            win.order     = ord;
            win.lane      = lane_idx_t'(l);
            win.excl_self = excl_self[l][s];
          end
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Backend stall/flush controller: age-ordered selective flush,
// stall propagation, frontend redirect register and stall watchdog.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter  int NUM_PIPE  = 2,
  parameter  int NUM_STAGE = 3,
  parameter  int PC_WIDTH  = 32,
  parameter  int WDT_WIDTH = 8,
  localparam int ORDER_W   = order_w(NUM_PIPE)
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [NUM_PIPE-1:0][NUM_STAGE-1:0]               slot_valid_i,
  input  logic [NUM_PIPE-1:0][NUM_STAGE-1:0][ORDER_W-1:0]  slot_order_i,
  input  logic [NUM_PIPE-1:0][NUM_STAGE-1:0]               stall_req_i,
  input  logic [NUM_PIPE-1:0][NUM_STAGE-1:0]               clr_req_i,
  input  logic [NUM_PIPE-1:0][NUM_STAGE-1:0]               clr_excl_self_i,
  input  logic [NUM_PIPE-1:0][NUM_STAGE-1:0][PC_WIDTH-1:0] redirect_pc_i,
  output logic [NUM_PIPE-1:0][NUM_STAGE-1:0]               stall_vec_o,
  output logic [NUM_PIPE-1:0][NUM_STAGE-1:0]               clr_vec_o,
  output logic                                             issue_stall_o,
  output logic                                             fe_flush_valid_o,
  output logic [PC_WIDTH-1:0]                              fe_flush_pc_o,
  input  logic                                             fe_flush_ready_i,
  output logic                                             wdt_timeout_o
);

  win_t                              win;
  logic [NUM_PIPE-1:0][NUM_STAGE-1:0] clr_raw;
  logic [NUM_PIPE-1:0][NUM_STAGE-1:0] stall_live;
  logic [NUM_STAGE-1:0]               stall_ge;
  logic                               accept;
  logic [PC_WIDTH-1:0]                win_pc;
  logic [WDT_WIDTH-1:0]               wdt_cnt;

  clr_oldest_arb #(
    .NUM_PIPE  (NUM_PIPE),
    .NUM_STAGE (NUM_STAGE),
    .ORDER_W   (ORDER_W)
  ) u_arb (
    .slot_valid (slot_valid_i),
    .clr_req    (clr_req_i),
    .excl_self  (clr_excl_self_i),
    .slot_order (slot_order_i),
    .win        (win)
  );

  // Everything younger than the winner, plus the winner unless excluded.
  always_comb begin
    order_idx_t so;
    stage_idx_t st;
    logic       same;
    so      = '0;
    st      = '0;
    same    = 1'b0;
    clr_raw = '0;
    for (int l = 0; l < NUM_PIPE; l++) begin
      for (int s = 0; s < NUM_STAGE; s++) begin
        so   = (NUM_PIPE > 1) ? order_idx_t'(slot_order_i[l][s]) : '0;
        st   = stage_idx_t'(s);
        same = (st == win.stage);
        clr_raw[l][s] = win.valid && (st < win.stage ||
          (same && so > win.order) ||
          (same && lane_idx_t'(l) == win.lane && !win.excl_self));
      end
    end
  end

  assign stall_live = slot_valid_i & stall_req_i & ~clr_raw;

  always_comb begin
    logic any;
    any      = 1'b0;
    stall_ge = '0;
    for (int s = NUM_STAGE - 1; s >= 0; s--) begin
      for (int l = 0; l < NUM_PIPE; l++) begin
        any = any | stall_live[l][s];
      end
      stall_ge[s] = any;
    end
  end

  always_comb begin
    accept = 1'b0;
    win_pc = '0;
    for (int s = 0; s < NUM_STAGE; s++) begin
      if (win.valid && win.stage == stage_idx_t'(s)) begin
        accept = !stall_ge[s];
        for (int l = 0; l < NUM_PIPE; l++) begin
          if (win.lane == lane_idx_t'(l)) win_pc = redirect_pc_i[l][s];
        end
      end
    end
  end

  always_comb begin
    stall_vec_o = '0;
    for (int l = 0; l < NUM_PIPE; l++) begin
      for (int s = 0; s < NUM_STAGE; s++) begin
        stall_vec_o[l][s] = stall_ge[s];
      end
    end
  end

  assign clr_vec_o     = accept ? clr_raw : '0;
  assign issue_stall_o = stall_ge[0] | fe_flush_valid_o | accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fe_flush_valid_o <= 1'b0;
      fe_flush_pc_o    <= '0;
    end else if (accept) begin
      fe_flush_valid_o <= 1'b1;
      fe_flush_pc_o    <= win_pc;
    end else if (fe_flush_ready_i) begin
      fe_flush_valid_o <= 1'b0;
    end
  end

  // Any stall reaches stage 0, so stall_ge[0] means "some slot held".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_cnt       <= '0;
      wdt_timeout_o <= 1'b0;
    end else if (stall_ge[0]) begin
      wdt_cnt       <= (&wdt_cnt) ? '0 : wdt_cnt + 1'b1;
      wdt_timeout_o <= &wdt_cnt;
    end else begin
      wdt_cnt       <= '0;
      wdt_timeout_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with an age-key reference model.
// Runs with a 4-bit watchdog so wrap behaviour is reachable quickly.
module tb_pipe_hazard_ctrl;

  localparam int NP = 2;
  localparam int NS = 3;
  localparam int PW = 32;
  localparam int WW = 4;
  localparam int OW = 1;
  localparam int WDT_PERIOD = 1 << WW;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0][NS-1:0]         slot_valid, stall_req, clr_req, excl;
  logic [NP-1:0][NS-1:0][OW-1:0] order;
  logic [NP-1:0][NS-1:0][PW-1:0] rpc;
  logic [NP-1:0][NS-1:0]         stall_vec, clr_vec;
  logic                          issue_stall, fe_valid, fe_ready, wdt_to;
  logic [PW-1:0]                 fe_pc;

  int n_checks = 0;
  int n_errors = 0;

  logic          m_valid, m_to;
  logic [PW-1:0] m_pc;
  int            m_run;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .NUM_PIPE  (NP),
    .NUM_STAGE (NS),
    .PC_WIDTH  (PW),
    .WDT_WIDTH (WW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .slot_valid_i     (slot_valid),
    .slot_order_i     (order),
    .stall_req_i      (stall_req),
    .clr_req_i        (clr_req),
    .clr_excl_self_i  (excl),
    .redirect_pc_i    (rpc),
    .stall_vec_o      (stall_vec),
    .clr_vec_o        (clr_vec),
    .issue_stall_o    (issue_stall),
    .fe_flush_valid_o (fe_valid),
    .fe_flush_pc_o    (fe_pc),
    .fe_flush_ready_i (fe_ready),
    .wdt_timeout_o    (wdt_to)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Age key: larger = older. Stage dominates, lower order is older.
  function automatic int age(input int l, input int s);
    return s * NP + (NP - 1 - int'(order[l][s]));
  endfunction

  function automatic void model(output logic [NP-1:0][NS-1:0] st,
                                output logic [NP-1:0][NS-1:0] cl,
                                output logic acc,
                                output logic [PW-1:0] pc);
    int wk, wl, ws, smax;
    logic wex;
    logic [NP-1:0][NS-1:0] raw;
    wk = -1; wl = 0; ws = 0; smax = -1; wex = 1'b0; raw = '0;
    for (int s = 0; s < NS; s++)
      for (int l = 0; l < NP; l++)
        if (slot_valid[l][s] && clr_req[l][s] && age(l, s) > wk) begin
          wk = age(l, s); wl = l; ws = s; wex = excl[l][s];
        end
    if (wk >= 0)
      for (int s = 0; s < NS; s++)
        for (int l = 0; l < NP; l++)
          raw[l][s] = (age(l, s) < wk) || (l == wl && s == ws && !wex);
    for (int s = 0; s < NS; s++)
      for (int l = 0; l < NP; l++)
        if (slot_valid[l][s] && stall_req[l][s] && !raw[l][s] && s > smax)
          smax = s;
    for (int s = 0; s < NS; s++)
      for (int l = 0; l < NP; l++)
        st[l][s] = (s <= smax);
    acc = (wk >= 0) && (ws > smax);
    cl  = acc ? raw : '0;
    pc  = acc ? rpc[wl][ws] : '0;
  endfunction

  always @(posedge clk or posedge rst) begin : mdl
    logic [NP-1:0][NS-1:0] st, cl;
    logic acc;
    logic [PW-1:0] pc;
    if (rst) begin
      m_valid <= 1'b0;
      m_pc    <= '0;
      m_run   <= 0;
      m_to    <= 1'b0;
    end else begin
      model(st, cl, acc, pc);
      if (acc) begin
        m_valid <= 1'b1;
        m_pc    <= pc;
      end else if (fe_ready) begin
        m_valid <= 1'b0;
      end
      if (|st) begin
        m_run <= m_run + 1;
        m_to  <= ((m_run + 1) % WDT_PERIOD) == 0;
      end else begin
        m_run <= 0;
        m_to  <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic [NP-1:0][NS-1:0] st, cl;
    logic acc, st0;
    logic [PW-1:0] pc;
    model(st, cl, acc, pc);
    st0 = 1'b0;
    for (int l = 0; l < NP; l++) st0 = st0 | st[l][0];
    for (int s = 0; s < NS; s++)
      for (int a = 0; a < NP; a++)
        for (int b = a + 1; b < NP; b++)
          if (slot_valid[a][s] && slot_valid[b][s] &&
              order[a][s] == order[b][s]) begin
            n_errors++;
            $display("FAIL illegal_order: stage %0d lanes %0d %0d", s, a, b);
          end
    chk("m_stall_vec", stall_vec, st);
    chk("m_clr_vec", clr_vec, cl);
    chk("m_issue_stall", issue_stall, st0 | (rst ? 1'b0 : m_valid) | acc);
    chk("m_fe_valid", fe_valid, rst ? 1'b0 : m_valid);
    chk("m_fe_pc", fe_pc, rst ? '0 : m_pc);
    chk("m_wdt", wdt_to, rst ? 1'b0 : m_to);
  end

  task automatic idle();
    slot_valid = '0;
    stall_req  = '0;
    clr_req    = '0;
    excl       = '0;
    for (int l = 0; l < NP; l++)
      for (int s = 0; s < NS; s++) begin
        order[l][s] = OW'(l);
        rpc[l][s]   = 32'h1000_0000 + 32'(l * 16 + s * 4);
      end
  endtask

  task automatic slot(input int l, input int s, input logic st,
                      input logic cl, input logic ex,
                      input logic [OW-1:0] ord, input logic [PW-1:0] pc);
    slot_valid[l][s] = 1'b1;
    stall_req[l][s]  = st;
    clr_req[l][s]    = cl;
    excl[l][s]       = ex;
    order[l][s]      = ord;
    rpc[l][s]        = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    fe_ready = 1'b0;
    idle();
    @(negedge clk);
    chk("rst_fe_valid", fe_valid, 0);
    chk("rst_fe_pc", fe_pc, 0);
    tick();
    rst = 1'b0;
    tick();

    // Lane 1 stage 1 (order 0) flushes, not excluded.
    slot(1, 1, 0, 1, 0, 0, 32'h1c00_0200);
    slot(0, 1, 0, 0, 0, 1, 32'h1c00_0204);
    @(negedge clk);
    chk("t1_clr", clr_vec, 6'h1B);
    chk("t1_stall", stall_vec, 6'h00);
    chk("t1_issue", issue_stall, 1);
    tick();
    idle();
    @(negedge clk);
    chk("t1_fe_valid", fe_valid, 1);
    chk("t1_fe_pc", fe_pc, 32'h1c00_0200);
    fe_ready = 1'b1;
    tick();
    fe_ready = 1'b0;
    @(negedge clk);
    chk("t1_drained", fe_valid, 0);

    // Same-stage ordering at stage 2 with exclude-self.
    tick();
    slot(0, 2, 0, 1, 1, 1, 32'h1c00_0300);
    slot(1, 2, 0, 0, 0, 0, 32'h1c00_0304);
    @(negedge clk);
    chk("t2_clr", clr_vec, 6'h1B);
    tick();
    idle();
    @(negedge clk);
    chk("t2_fe_pc", fe_pc, 32'h1c00_0300);
    fe_ready = 1'b1;
    tick();
    fe_ready = 1'b0;

    // Older stall blocks a younger flush.
    slot(1, 2, 1, 0, 0, 1, 32'h1c00_0f00);
    slot(0, 1, 0, 1, 0, 0, 32'h1c00_0f04);
    @(negedge clk);
    chk("t3_clr", clr_vec, 6'h00);
    chk("t3_stall", stall_vec, 6'h3F);
    chk("t3_issue", issue_stall, 1);
    tick();
    idle();
    @(negedge clk);
    chk("t3_no_load", fe_valid, 0);

    // Redirect handshake with overwrite on the ready edge.
    tick();
    slot(0, 0, 0, 1, 1, 0, 32'h1c00_0100);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", fe_valid, 1);
      chk("t4_hold_pc", fe_pc, 32'h1c00_0100);
      chk("t4_hold_issue", issue_stall, 1);
      tick();
    end
    slot(1, 1, 0, 1, 0, 1, 32'h1c00_0080);
    fe_ready = 1'b1;
    @(negedge clk);
    chk("t4_clr2", clr_vec, 6'h19);
    chk("t4_old_pc", fe_pc, 32'h1c00_0100);
    tick();
    idle();
    fe_ready = 1'b0;
    @(negedge clk);
    chk("t4_new_valid", fe_valid, 1);
    chk("t4_new_pc", fe_pc, 32'h1c00_0080);
    fe_ready = 1'b1;
    tick();
    fe_ready = 1'b0;
    @(negedge clk);
    chk("t4_drained", fe_valid, 0);

    // Watchdog: continuous stall, then a one-cycle gap.
    tick();
    slot(0, 0, 1, 0, 0, 0, 32'h0);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      chk("t5_wdt_a", wdt_to, (i == 17 || i == 33));
      tick();
    end
    idle();
    @(negedge clk);
    tick();
    slot(0, 0, 1, 0, 0, 0, 32'h0);
    for (int i = 42; i <= 60; i++) begin
      @(negedge clk);
      chk("t5_wdt_b", wdt_to, (i == 58));
      tick();
    end
    idle();

    // Asynchronous reset drops a pending redirect.
    tick();
    slot(0, 1, 0, 1, 0, 0, 32'h1c00_0400);
    tick();
    idle();
    @(negedge clk);
    chk("t6_pending", fe_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", fe_valid, 0);
    chk("t6_rst_pc", fe_pc, 0);
    chk("t6_rst_wdt", wdt_to, 0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("t6_no_replay", fe_valid, 0);
    chk("t6_no_replay_pc", fe_pc, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
